// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Hazard and forwarding control for a 5-stage in-order pipeline with a
// variable-latency data memory.
//   - Load-use hazards stall IF/ID for one cycle and bubble ID/EX.
//   - Taken branches flush IF/ID and bubble ID/EX.
//   - Outstanding data-memory accesses freeze the back end; a memory that
//     never answers within TIMEOUT wait cycles drives a sticky fault.
//   - Operand forwarding selects EX/MEM over MEM/WB over the register file.
//   - A saturating counter accumulates cycles in which the PC was held.
//
// Ports
//   Clock_i, Reset_i              clock, asynchronous active-high reset
//   IdRs1_i/IdRs2_i, IdUses*_i    ID-stage sources and their use flags
//   ExRs1_i/ExRs2_i               EX-stage sources (forwarding compare)
//   ExRd_i, ExRegWrite_i, ExMemRead_i   EX destination / write / load flags
//   MemRd_i, MemRegWrite_i        MEM-stage destination and write flag
//   WbRd_i, WbRegWrite_i          WB-stage destination and write flag
//   BranchTaken_i                 EX resolved a taken branch this cycle
//   MemReq_i, MemReady_i          data-memory request / completion
//   PcWrite_o, IfIdWrite_o        PC and IF/ID update enables
//   IfIdFlush_o, IdExBubble_o     zero IF/ID, inject NOP into ID/EX
//   Freeze_o                      hold ID/EX, EX/MEM, MEM/WB
//   ForwardA_o, ForwardB_o        10 EX/MEM, 01 MEM/WB, 00 register file
//   Fault_o                       sticky memory-timeout indication
//   StallCount_o                  saturating count of PC-hold cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic [2:0]       IdRs1_i,
  input  logic [2:0]       IdRs2_i,
  input  logic             IdUsesRs1_i,
  input  logic             IdUsesRs2_i,
  input  logic [2:0]       ExRs1_i,
  input  logic [2:0]       ExRs2_i,
  input  logic [2:0]       ExRd_i,
  input  logic             ExRegWrite_i,
  input  logic             ExMemRead_i,
  input  logic [2:0]       MemRd_i,
  input  logic             MemRegWrite_i,
  input  logic [2:0]       WbRd_i,
  input  logic             WbRegWrite_i,
  input  logic             BranchTaken_i,
  input  logic             MemReq_i,
  input  logic             MemReady_i,
  output logic             PcWrite_o,
  output logic             IfIdWrite_o,
  output logic             IfIdFlush_o,
  output logic             IdExBubble_o,
  output logic             Freeze_o,
  output logic [1:0]       ForwardA_o,
  output logic [1:0]       ForwardB_o,
  output logic             Fault_o,
  output logic [CNT_W-1:0] StallCount_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic mem_stall;
  logic load_use;
  logic freeze;

  // Forwarding source for one EX operand; the younger EX/MEM result wins.
  function automatic logic [1:0] fwd_sel(input logic [2:0] src);
    if (MemRegWrite_i && (MemRd_i == src))     return 2'b10;
    else if (WbRegWrite_i && (WbRd_i == src))  return 2'b01;
    else                                       return 2'b00;
  endfunction

  assign mem_stall = MemReq_i & ~MemReady_i;
  assign load_use  = ExMemRead_i & ExRegWrite_i &
                     ((IdUsesRs1_i & (IdRs1_i == ExRd_i)) |
                      (IdUsesRs2_i & (IdRs2_i == ExRd_i)));
  // A waiting access keeps the pipe frozen even if MemReq drops, until
  // the memory reports completion.
  assign freeze    = mem_stall |
                     ((state_q == MEM_WAIT) & ~MemReady_i) |
                     (state_q == FAULT);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (MemReady_i) begin
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == TIMEOUT_C) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      FAULT: ;
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
  end

  // Output priority: reset, then freeze, then branch flush, then load-use.
  always_comb begin
    PcWrite_o    = 1'b1;
    IfIdWrite_o  = 1'b1;
    IfIdFlush_o  = 1'b0;
    IdExBubble_o = 1'b0;
    Freeze_o     = 1'b0;
    ForwardA_o   = 2'b00;
    ForwardB_o   = 2'b00;
    if (Reset_i) begin
      PcWrite_o    = 1'b0;
      IfIdWrite_o  = 1'b0;
      IfIdFlush_o  = 1'b1;
      IdExBubble_o = 1'b1;
    end else begin
      ForwardA_o = fwd_sel(ExRs1_i);
      ForwardB_o = fwd_sel(ExRs2_i);
      if (freeze) begin
        Freeze_o    = 1'b1;
        PcWrite_o   = 1'b0;
        IfIdWrite_o = 1'b0;
      end else if (BranchTaken_i) begin
        IfIdFlush_o  = 1'b1;
        IdExBubble_o = 1'b1;
      end else if (load_use) begin
        PcWrite_o    = 1'b0;
        IfIdWrite_o  = 1'b0;
        IdExBubble_o = 1'b1;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!PcWrite_o && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign Fault_o      = (state_q == FAULT);
  assign StallCount_o = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] IdRs1, IdRs2, ExRs1, ExRs2, ExRd, MemRd, WbRd;
  logic IdUsesRs1, IdUsesRs2, ExRegWrite, ExMemRead, MemRegWrite, WbRegWrite;
  logic BranchTaken, MemReq, MemReady;

  // Index 0: default parameters; index 1: CNT_W=4, TIMEOUT=3.
  logic       pc_o[2], ifid_o[2], flush_o[2], bub_o[2], frz_o[2], flt_o[2];
  logic [1:0] fa_o[2], fb_o[2];
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  pipeline_hazard_controller dut (
    .Clock_i(clk), .Reset_i(rst),
    .IdRs1_i(IdRs1), .IdRs2_i(IdRs2), .IdUsesRs1_i(IdUsesRs1), .IdUsesRs2_i(IdUsesRs2),
    .ExRs1_i(ExRs1), .ExRs2_i(ExRs2), .ExRd_i(ExRd), .ExRegWrite_i(ExRegWrite),
    .ExMemRead_i(ExMemRead), .MemRd_i(MemRd), .MemRegWrite_i(MemRegWrite),
    .WbRd_i(WbRd), .WbRegWrite_i(WbRegWrite), .BranchTaken_i(BranchTaken),
    .MemReq_i(MemReq), .MemReady_i(MemReady),
    .PcWrite_o(pc_o[0]), .IfIdWrite_o(ifid_o[0]), .IfIdFlush_o(flush_o[0]),
    .IdExBubble_o(bub_o[0]), .Freeze_o(frz_o[0]), .ForwardA_o(fa_o[0]),
    .ForwardB_o(fb_o[0]), .Fault_o(flt_o[0]), .StallCount_o(sc_a)
  );

  pipeline_hazard_controller #(.TIMEOUT(3), .CNT_W(4)) dut4 (
    .Clock_i(clk), .Reset_i(rst),
    .IdRs1_i(IdRs1), .IdRs2_i(IdRs2), .IdUsesRs1_i(IdUsesRs1), .IdUsesRs2_i(IdUsesRs2),
    .ExRs1_i(ExRs1), .ExRs2_i(ExRs2), .ExRd_i(ExRd), .ExRegWrite_i(ExRegWrite),
    .ExMemRead_i(ExMemRead), .MemRd_i(MemRd), .MemRegWrite_i(MemRegWrite),
    .WbRd_i(WbRd), .WbRegWrite_i(WbRegWrite), .BranchTaken_i(BranchTaken),
    .MemReq_i(MemReq), .MemReady_i(MemReady),
    .PcWrite_o(pc_o[1]), .IfIdWrite_o(ifid_o[1]), .IfIdFlush_o(flush_o[1]),
    .IdExBubble_o(bub_o[1]), .Freeze_o(frz_o[1]), .ForwardA_o(fa_o[1]),
    .ForwardB_o(fb_o[1]), .Fault_o(flt_o[1]), .StallCount_o(sc_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, whether a fault has latched, how many
  // consecutive unanswered wait cycles are pending (0 = no access waiting),
  // and the number of cycles the PC has been held so far.
  bit m_fault[2];
  int m_wait[2];
  int m_cnt[2];
  int m_to[2]  = '{15, 3};
  int m_max[2] = '{65535, 15};

  task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, k, got, exp);
    end
  endtask

  function automatic logic [31:0] sc_of(input int k);
    return (k == 0) ? {16'd0, sc_a} : {28'd0, sc_b};
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [2:0] src);
    if (MemRegWrite && MemRd == src) return 2'b10;
    if (WbRegWrite && WbRd == src)   return 2'b01;
    return 2'b00;
  endfunction

  task automatic exp_out(input int k, output bit pc, output bit ifid, output bit fl,
                         output bit bub, output bit frz, output logic [1:0] fa,
                         output logic [1:0] fb);
    bit ms, lu;
    ms = MemReq && !MemReady;
    lu = ExMemRead && ExRegWrite &&
         ((IdUsesRs1 && IdRs1 == ExRd) || (IdUsesRs2 && IdRs2 == ExRd));
    fa = fwd_exp(ExRs1);
    fb = fwd_exp(ExRs2);
    frz = 0;
    if (rst) begin
      pc = 0; ifid = 0; fl = 1; bub = 1; fa = 2'b00; fb = 2'b00;
    end else if (m_fault[k] || ms || (m_wait[k] > 0 && !MemReady)) begin
      pc = 0; ifid = 0; fl = 0; bub = 0; frz = 1;
    end else if (BranchTaken) begin
      pc = 1; ifid = 1; fl = 1; bub = 1;
    end else if (lu) begin
      pc = 0; ifid = 0; fl = 0; bub = 1;
    end else begin
      pc = 1; ifid = 1; fl = 0; bub = 0;
    end
  endtask

  task automatic check_all();
    bit pc, ifid, fl, bub, frz;
    logic [1:0] fa, fb;
    for (int k = 0; k < 2; k++) begin
      exp_out(k, pc, ifid, fl, bub, frz, fa, fb);
      chk("PcWrite", k, 32'(pc_o[k]), 32'(pc));
      chk("IfIdWrite", k, 32'(ifid_o[k]), 32'(ifid));
      chk("IfIdFlush", k, 32'(flush_o[k]), 32'(fl));
      chk("IdExBubble", k, 32'(bub_o[k]), 32'(bub));
      chk("Freeze", k, 32'(frz_o[k]), 32'(frz));
      chk("ForwardA", k, 32'(fa_o[k]), 32'(fa));
      chk("ForwardB", k, 32'(fb_o[k]), 32'(fb));
      chk("Fault", k, 32'(flt_o[k]), 32'(m_fault[k]));
      chk("StallCount", k, sc_of(k), 32'(m_cnt[k]));
    end
  endtask

  task automatic model_edge();
    bit pc, ifid, fl, bub, frz;
    logic [1:0] fa, fb;
    for (int k = 0; k < 2; k++) begin
      exp_out(k, pc, ifid, fl, bub, frz, fa, fb);
      if (!pc && m_cnt[k] < m_max[k]) m_cnt[k]++;
      if (!m_fault[k]) begin
        if (m_wait[k] == 0) begin
          if (MemReq && !MemReady) m_wait[k] = 1;
        end else if (MemReady) m_wait[k] = 0;
        else if (m_wait[k] == m_to[k]) m_fault[k] = 1;
        else m_wait[k]++;
      end
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_fault[k] = 0; m_wait[k] = 0; m_cnt[k] = 0;
    end
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs are
  // compared on the falling edge, and the model advances on the rising edge.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle();
    IdRs1 = 0; IdRs2 = 0; ExRs1 = 0; ExRs2 = 0; ExRd = 0; MemRd = 0; WbRd = 0;
    IdUsesRs1 = 0; IdUsesRs2 = 0; ExRegWrite = 0; ExMemRead = 0;
    MemRegWrite = 0; WbRegWrite = 0; BranchTaken = 0; MemReq = 0; MemReady = 0;
  endtask

  // Asserted mid-cycle so the asynchronous clear is observable before any edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  function automatic logic [2:0] pick(input logic [2:0] near);
    return ($urandom_range(0, 1) == 0) ? near : 3'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_clear();
    #1;
    check_all();
    cycle();
    rst = 1'b0;
    cycle();

    // Load-use on Rs2 against a load in EX.
    do_reset();
    idle();
    ExMemRead = 1; ExRegWrite = 1; ExRd = 3; IdUsesRs2 = 1; IdRs2 = 3;
    #1;
    chk("LU_PcWrite", 0, 32'(pc_o[0]), 0);
    chk("LU_IdExBubble", 0, 32'(bub_o[0]), 1);
    cycle();
    chk("LU_StallCount", 0, sc_of(0), 1);
    idle();
    cycle();

    // Load-use on register 0 via Rs1: register 0 is not special.
    ExMemRead = 1; ExRegWrite = 1; ExRd = 0; IdUsesRs1 = 1; IdRs1 = 0;
    #1;
    chk("LU_R0_PcWrite", 0, 32'(pc_o[0]), 0);
    cycle();
    idle();

    // Forwarding: EX/MEM wins over MEM/WB; MEM/WB-only gives 01.
    MemRegWrite = 1; MemRd = 5; WbRegWrite = 1; WbRd = 5; ExRs1 = 5; ExRs2 = 2;
    #1;
    chk("FwdA_exmem", 0, 32'(fa_o[0]), 32'(2'b10));
    chk("FwdB_none", 0, 32'(fb_o[0]), 32'(2'b00));
    cycle();
    MemRd = 4; WbRd = 2;
    #1;
    chk("FwdB_memwb", 0, 32'(fb_o[0]), 32'(2'b01));
    cycle();
    idle();

    // Branch and load-use together: branch wins.
    BranchTaken = 1; ExMemRead = 1; ExRegWrite = 1; ExRd = 6; IdUsesRs1 = 1; IdRs1 = 6;
    #1;
    chk("BR_IfIdFlush", 0, 32'(flush_o[0]), 1);
    chk("BR_IdExBubble", 0, 32'(bub_o[0]), 1);
    chk("BR_PcWrite", 0, 32'(pc_o[0]), 1);
    cycle();
    idle();

    // Memory answering in the same cycle causes no freeze.
    MemReq = 1; MemReady = 1;
    #1;
    chk("ZeroWait_Freeze", 0, 32'(frz_o[0]), 0);
    cycle();
    cycle();
    idle();

    // Four-cycle memory wait, then completion.
    do_reset();
    idle();
    MemReq = 1; MemReady = 0;
    for (int i = 0; i < 4; i++) cycle();
    MemReady = 1;
    #1;
    chk("MW_Freeze_done", 0, 32'(frz_o[0]), 0);
    cycle();
    idle();
    cycle();
    chk("MW_StallCount", 0, sc_of(0), 4);
    chk("MW_Fault", 0, 32'(flt_o[0]), 0);

    // Memory never answers: fault latches and survives MemReq dropping.
    do_reset();
    idle();
    MemReq = 1; MemReady = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("TO_Fault", 0, 32'(flt_o[0]), 1);
    MemReq = 0; MemReady = 1;
    cycle();
    cycle();
    chk("TO_Fault_sticky", 0, 32'(flt_o[0]), 1);
    chk("TO_Freeze_sticky", 0, 32'(frz_o[0]), 1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("TO_Fault_async_clr", 0, 32'(flt_o[0]), 0);
    chk("TO_Stall_async_clr", 0, sc_of(0), 0);
    cycle();
    rst = 1'b0;
    idle();
    cycle();
    chk("TO_run_after_reset", 0, 32'(pc_o[0]), 1);

    // Saturation of the narrow counter after 20 stall cycles.
    do_reset();
    idle();
    ExMemRead = 1; ExRegWrite = 1; ExRd = 7; IdUsesRs1 = 1; IdRs1 = 7;
    for (int i = 0; i < 20; i++) cycle();
    idle();
    cycle();
    chk("SAT_StallCount4", 1, sc_of(1), 15);
    chk("SAT_StallCount16", 0, sc_of(0), 20);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if (n % 97 == 96) do_reset();
      ExRd = 3'($urandom_range(0, 7));
      MemRd = 3'($urandom_range(0, 7));
      WbRd = pick(MemRd);
      IdRs1 = pick(ExRd); IdRs2 = pick(ExRd);
      ExRs1 = pick(MemRd); ExRs2 = pick(WbRd);
      IdUsesRs1 = 1'($urandom_range(0, 1)); IdUsesRs2 = 1'($urandom_range(0, 1));
      ExRegWrite = 1'($urandom_range(0, 1)); ExMemRead = 1'($urandom_range(0, 1));
      MemRegWrite = 1'($urandom_range(0, 1)); WbRegWrite = 1'($urandom_range(0, 1));
      BranchTaken = ($urandom_range(0, 4) == 0);
      MemReq = 1'($urandom_range(0, 1));
      MemReady = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter TIMEOUT, default 15: max consecutive memory-wait cycles before fault; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of stall performance counter.
REQ-003 Clock  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 IdRs1, IdRs2  input  3 each  source register addresses of instruction in ID.
REQ-006 IdUsesRs1, IdUsesRs2  input  1 each  ID instruction actually reads that source.
REQ-007 ExRs1, ExRs2  input  3 each  source register addresses of instruction in EX.
REQ-008 ExRd  input  3; ExRegWrite, ExMemRead  input  1 each  EX destination, writes-register flag, is-load flag.
REQ-009 MemRd  input  3; MemRegWrite  input  1  MEM-stage destination and write flag.
REQ-010 WbRd  input  3; WbRegWrite  input  1  WB-stage destination and write flag.
REQ-011 BranchTaken  input  1  EX resolved a taken branch/jump this cycle.
REQ-012 MemReq, MemReady  input  1 each  MEM stage requests data memory; memory completes the access.
REQ-013 PcWrite, IfIdWrite  output  1 each  enable PC and IF/ID register update.
REQ-014 IfIdFlush, IdExBubble  output  1 each  zero IF/ID; load NOP into ID/EX.
REQ-015 Freeze  output  1  hold ID/EX, EX/MEM, MEM/WB registers unchanged.
REQ-016 ForwardA, ForwardB  output  2 each  EX operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-017 Fault  output  1  sticky memory-timeout indication.
REQ-018 StallCount  output  CNT_W  saturating count of stalled cycles.

Function
REQ-019 No register is hardwired; all eight addresses, including 0, participate in hazard/forward compares.
REQ-020 FSM states RUN, MEM_WAIT, FAULT; WaitCnt is an 8-bit counter.
REQ-021 MemStall = MemReq & !MemReady; LoadUse = ExMemRead & ExRegWrite & ((IdUsesRs1 & IdRs1==ExRd) | (IdUsesRs2 & IdRs2==ExRd)).
REQ-022 RUN: MemStall -> MEM_WAIT, WaitCnt<=1; else stay RUN.
REQ-023 MEM_WAIT: MemReady -> RUN, WaitCnt<=0; else if WaitCnt==TIMEOUT -> FAULT; else WaitCnt<=WaitCnt+1.
REQ-024 FAULT: held until Reset; Fault=1, Freeze=1, PcWrite=0, IfIdWrite=0.
REQ-025 Freeze=1 whenever MemStall, or state MEM_WAIT without MemReady, or FAULT; Freeze also forces PcWrite=0, IfIdWrite=0, IfIdFlush=0, IdExBubble=0.
REQ-026 Priority, combinational in the same cycle: Freeze > BranchTaken > LoadUse.
REQ-027 BranchTaken (not frozen): IfIdFlush=1, IdExBubble=1, PcWrite=1, IfIdWrite=1, for exactly that cycle.
REQ-028 LoadUse (not frozen, no branch): PcWrite=0, IfIdWrite=0, IdExBubble=1 for one cycle; the stalled instruction re-evaluates next cycle.
REQ-029 Otherwise PcWrite=1, IfIdWrite=1, IfIdFlush=0, IdExBubble=0.
REQ-030 ForwardA=10 if MemRegWrite & MemRd==ExRs1; else 01 if WbRegWrite & WbRd==ExRs1; else 00; ForwardB identically on ExRs2; EX/MEM wins when both match.
REQ-031 Forwarding outputs are purely combinational, independent of state and Freeze.
REQ-032 StallCount increments by 1 on each clock edge where PcWrite==0 and Reset==0; holds at 2^CNT_W-1.
REQ-033 MemReady asserted in the same cycle as MemReq causes no freeze and no state change.

Reset
REQ-034 Reset asserted: state<=RUN, WaitCnt<=0, Fault<=0, StallCount<=0 asynchronously, even mid MEM_WAIT or FAULT.
REQ-035 While Reset high: PcWrite=0, IfIdWrite=0, IfIdFlush=1, IdExBubble=1, Freeze=0, ForwardA=ForwardB=00.
REQ-036 First edge after Reset deasserts operates from RUN with normal combinational rules.

Verification
REQ-037 ExMemRead=1, ExRegWrite=1, ExRd=3, IdUsesRs2=1, IdRs2=3 -> PcWrite=0, IfIdWrite=0, IdExBubble=1 one cycle; StallCount 0->1.
REQ-038 MemRegWrite=1, MemRd=5, WbRegWrite=1, WbRd=5, ExRs1=5, ExRs2=2 -> ForwardA=10, ForwardB=00.
REQ-039 Same-cycle BranchTaken=1 and LoadUse -> IfIdFlush=1, IdExBubble=1, PcWrite=1.
REQ-040 MemReq=1, MemReady=0 for 4 cycles then 1 -> Freeze=1 for 4 cycles, back to RUN, StallCount=4, Fault=0.
REQ-041 MemReq=1, MemReady=0 held, TIMEOUT=15 -> FAULT entered after WaitCnt reaches 15, Fault=1 sticky; Reset pulse -> Fault=0, state RUN.
REQ-042 StallCount preset near max via CNT_W=4 and 20 stall cycles -> StallCount=15, no wrap.
